// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core: one shared ALU sequenced by an IF/ID/EX/MEM/WB FSM, ready-qualified fetch and data access.
// Define MULTICYCLE_MIPS_TRAP_EN to halt on unrecognised instructions; otherwise they retire as NOPs.
module multicycle_mips #(
    parameter int          DMEM_AW  = 7,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        IR_addr,
    output logic               IR_req,
    input  logic [31:0]        IR,
    input  logic               IR_valid,
    output logic               CEN,
    output logic               OEN,
    output logic               WEN,
    output logic [DMEM_AW-1:0] A,
    output logic [31:0]        WriteDataMem,
    input  logic [31:0]        ReadDataMem,
    input  logic               Mem_ready,
    output logic [31:0]        RF_writedata,
    output logic               halt
);

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [3:0] {C_RALU, C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_BAD} cls_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    state_t      state;
    logic [31:0] pc, ir, reg_a, reg_b, imm_sext, alu_out, mdr;
    logic [31:0] rf [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, dest;
    cls_t        cls;
    alu_op_t     r_op, alu_op;
    logic [31:0] alu_x, alu_y, alu_res, wb_data, jump_target;

    assign opcode      = ir[31:26];
    assign funct       = ir[5:0];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign dest        = (opcode == 6'h00) ? rd : rt;
    assign wb_data     = (cls == C_LW) ? mdr : alu_out;
    assign jump_target = {pc[31:28], ir[25:0], 2'b00};
    assign IR_addr     = pc;

    always_comb begin
        cls  = C_BAD;
        r_op = ALU_ADD;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: cls = C_RALU;
                    6'h22: begin cls = C_RALU; r_op = ALU_SUB; end
                    6'h24: begin cls = C_RALU; r_op = ALU_AND; end
                    6'h25: begin cls = C_RALU; r_op = ALU_OR;  end
                    6'h2A: begin cls = C_RALU; r_op = ALU_SLT; end
                    6'h08: cls = C_JR;
                    default: cls = C_BAD;
                endcase
            end
            6'h08:   cls = C_ADDI;
            6'h0D:   cls = C_ORI;
            6'h23:   cls = C_LW;
            6'h2B:   cls = C_SW;
            6'h04:   cls = C_BEQ;
            6'h02:   cls = C_J;
            6'h03:   cls = C_JAL;
            default: cls = C_BAD;
        endcase
    end

    // The single ALU computes PC+4 in IF and the class-specific result (or branch target) in EX.
    always_comb begin
        alu_x  = reg_a;
        alu_y  = reg_b;
        alu_op = ALU_ADD;
        if (state == S_IF) begin
            alu_x = pc;
            alu_y = 32'd4;
        end else begin
            case (cls)
                C_RALU:            alu_op = r_op;
                C_ADDI, C_LW, C_SW: alu_y = imm_sext;
                C_ORI: begin
                    alu_y  = {16'h0, ir[15:0]};
                    alu_op = ALU_OR;
                end
                C_BEQ: begin
                    alu_x = pc;
                    alu_y = {imm_sext[29:0], 2'b00};
                end
                default: alu_op = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_res = alu_x - alu_y;
            ALU_AND: alu_res = alu_x & alu_y;
            ALU_OR:  alu_res = alu_x | alu_y;
            ALU_SLT: alu_res = {31'h0, $signed(alu_x) < $signed(alu_y)};
            default: alu_res = alu_x + alu_y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IF;
            pc           <= RESET_PC;
            ir           <= '0;
            reg_a        <= '0;
            reg_b        <= '0;
            imm_sext     <= '0;
            alu_out      <= '0;
            mdr          <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            RF_writedata <= '0;
            halt         <= 1'b0;
            IR_req       <= 1'b0;
            CEN          <= 1'b1;
            OEN          <= 1'b1;
            WEN          <= 1'b1;
            A            <= '0;
            WriteDataMem <= '0;
        end else begin
            case (state)
                S_IF: begin
                    // IR_req is low for the first IF cycle after reset, so no fetch is accepted then.
                    if (IR_req && IR_valid) begin
                        ir     <= IR;
                        pc     <= alu_res;
                        IR_req <= 1'b0;
                        state  <= S_ID;
                    end else begin
                        IR_req <= 1'b1;
                    end
                end
                S_ID: begin
                    reg_a    <= rf[rs];
                    reg_b    <= rf[rt];
                    imm_sext <= {{16{ir[15]}}, ir[15:0]};
                    if (cls == C_BAD) begin
`ifdef MULTICYCLE_MIPS_TRAP_EN
                        state <= S_HALT;
                        halt  <= 1'b1;
`else
                        state  <= S_IF;
                        IR_req <= 1'b1;
`endif
                    end else begin
                        state <= S_EX;
                    end
                end
                S_EX: begin
                    case (cls)
                        C_LW, C_SW: begin
                            alu_out      <= alu_res;
                            A            <= alu_res[DMEM_AW+1:2];
                            WriteDataMem <= reg_b;
                            CEN          <= 1'b0;
                            OEN          <= (cls != C_LW);
                            WEN          <= (cls != C_SW);
                            state        <= S_MEM;
                        end
                        C_BEQ: begin
                            if (reg_a == reg_b) pc <= alu_res;
                            state  <= S_IF;
                            IR_req <= 1'b1;
                        end
                        C_J, C_JAL: begin
                            pc <= jump_target;
                            if (cls == C_JAL) begin
                                rf[31]       <= pc;
                                RF_writedata <= pc;
                            end
                            state  <= S_IF;
                            IR_req <= 1'b1;
                        end
                        C_JR: begin
                            pc     <= reg_a;
                            state  <= S_IF;
                            IR_req <= 1'b1;
                        end
                        default: begin
                            alu_out <= alu_res;
                            state   <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (Mem_ready) begin
                        CEN <= 1'b1;
                        OEN <= 1'b1;
                        WEN <= 1'b1;
                        if (cls == C_LW) begin
                            mdr   <= ReadDataMem;
                            state <= S_WB;
                        end else begin
                            state  <= S_IF;
                            IR_req <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    if (dest != 5'd0) rf[dest] <= wb_data;
                    RF_writedata <= wb_data;
                    state        <= S_IF;
                    IR_req       <= 1'b1;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_mips.sv
// Directed bench for multicycle_mips: feeds instructions by expected address, models data memory, scoreboards RF_writedata.
module tb_multicycle_mips;
    localparam int AW = 7;

    logic          clk;
    logic          rst;
    logic [31:0]   IR_addr;
    logic          IR_req;
    logic [31:0]   IR;
    logic          IR_valid;
    logic          CEN, OEN, WEN;
    logic [AW-1:0] A;
    logic [31:0]   WriteDataMem;
    logic [31:0]   ReadDataMem;
    logic          Mem_ready;
    logic [31:0]   RF_writedata;
    logic          halt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_fetch = -1;
    logic [31:0] exp_q [$];

    multicycle_mips #(.DMEM_AW(AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .IR_addr(IR_addr), .IR_req(IR_req), .IR(IR), .IR_valid(IR_valid),
        .CEN(CEN), .OEN(OEN), .WEN(WEN), .A(A),
        .WriteDataMem(WriteDataMem), .ReadDataMem(ReadDataMem), .Mem_ready(Mem_ready),
        .RF_writedata(RF_writedata), .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no end, expected end of test");
        $fatal(1, "timeout");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (IR_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, " req"}, IR_req, 1'b1);
    endtask

    // Completion of the previous instruction is observed at the start of the next fetch.
    task automatic fetch(input string tag, input logic [31:0] exp_pc, input logic [31:0] instr,
                         input int stall, input int exp_gap, input bit has_wd, input logic [31:0] wd);
        int held = 0;
        wait_req(tag);
        chk32({tag, " addr"}, IR_addr, exp_pc);
        if (exp_gap >= 0 && last_fetch >= 0) chk32({tag, " gap"}, cyc - last_fetch, exp_gap);
        last_fetch = cyc;
        if (exp_q.size() > 0) chk32({tag, " prev_wd"}, RF_writedata, exp_q.pop_front());
        if (has_wd) exp_q.push_back(wd);
        repeat (stall) begin
            IR_valid = 1'b0;
            @(negedge clk);
            if (IR_req === 1'b1) held++;
        end
        if (stall > 0) chk32({tag, " req_held"}, held, stall);
        IR = instr;
        IR_valid = 1'b1;
        @(negedge clk);
        IR_valid = 1'b0;
        IR = 32'h0;
    endtask

    task automatic mem_access(input string tag, input logic [31:0] exp_a, input logic exp_oen,
                              input logic exp_wen, input logic [31:0] exp_wdm, input int stall,
                              input logic [31:0] rdata);
        int n = 0;
        int held = 1;
        logic [AW-1:0] ea;
        ea = exp_a[AW-1:0];
        while (CEN !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, " cen"}, CEN, 1'b0);
        chk32({tag, " A"}, {25'h0, A}, exp_a);
        chk1({tag, " oen"}, OEN, exp_oen);
        chk1({tag, " wen"}, WEN, exp_wen);
        if (!exp_wen) chk32({tag, " wdata"}, WriteDataMem, exp_wdm);
        repeat (stall) begin
            @(negedge clk);
            if (CEN === 1'b0 && OEN === exp_oen && WEN === exp_wen && A === ea) held++;
        end
        chk32({tag, " strobe_cycles"}, held, stall + 1);
        ReadDataMem = rdata;
        Mem_ready = 1'b1;
        @(negedge clk);
        Mem_ready = 1'b0;
        chk32({tag, " release"}, {29'h0, CEN, OEN, WEN}, 32'h7);
    endtask

    initial begin
        int n;
        int held;
        rst = 1'b1;
        IR = 32'h0;
        IR_valid = 1'b0;
        ReadDataMem = 32'h0;
        Mem_ready = 1'b0;

        @(negedge clk);
        chk32("rst addr", IR_addr, 32'h0);
        chk1("rst req", IR_req, 1'b0);
        chk32("rst strobes", {29'h0, CEN, OEN, WEN}, 32'h7);
        chk32("rst A", {25'h0, A}, 32'h0);
        chk32("rst wdm", WriteDataMem, 32'h0);
        chk32("rst wd", RF_writedata, 32'h0);
        chk1("rst halt", halt, 1'b0);
        @(negedge clk);
        chk1("rst req2", IR_req, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk1("first req", IR_req, 1'b1);

        fetch("addi1", 32'h00, 32'h20010005, 0, -1, 1, 32'h5);
        fetch("addi2", 32'h04, 32'h2002FFFD, 1,  4, 1, 32'hFFFFFFFD);
        fetch("slt",   32'h08, 32'h0041182A, 0,  5, 1, 32'h1);
        fetch("add",   32'h0C, 32'h00222820, 0,  4, 1, 32'h2);
        fetch("beq_t", 32'h10, 32'h1021FFFF, 0,  4, 0, 32'h0);
        fetch("sub",   32'h10, 32'h00223022, 0,  3, 1, 32'h8);
        fetch("sw",    32'h14, 32'hAC010008, 0,  4, 0, 32'h0);
        mem_access("sw_mem", 32'h2, 1'b1, 1'b0, 32'h5, 2, 32'h0);
        fetch("lw",    32'h18, 32'h8C040008, 0,  6, 1, 32'h5);
        mem_access("lw_mem", 32'h2, 1'b0, 1'b1, 32'h0, 2, 32'h5);
        fetch("beq_n", 32'h1C, 32'h10220005, 0,  7, 0, 32'h0);
        fetch("jal",   32'h20, 32'h0C000040, 0,  3, 1, 32'h24);
        fetch("ori",   32'h100, 32'h34078001, 0, 3, 1, 32'h8001);
        fetch("and",   32'h104, 32'h00414024, 0, 4, 1, 32'h5);
        fetch("jr",    32'h108, 32'h03E00008, 0, 4, 0, 32'h0);
        fetch("lw_rst", 32'h24, 32'h8C0A0004, 3, 3, 0, 32'h0);

        n = 0;
        while (CEN !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk32("lw_rst A", {25'h0, A}, 32'h1);
        chk1("lw_rst oen", OEN, 1'b0);
        rst = 1'b1;
        Mem_ready = 1'b1;
        ReadDataMem = 32'hDEADBEEF;
        @(negedge clk);
        chk32("midmem strobes", {29'h0, CEN, OEN, WEN}, 32'h7);
        chk32("midmem pc", IR_addr, 32'h0);
        chk32("midmem wd", RF_writedata, 32'h0);
        chk1("midmem req", IR_req, 1'b0);
        rst = 1'b0;
        Mem_ready = 1'b0;
        last_fetch = -1;

        fetch("addi_r0", 32'h00, 32'h20000007, 0, -1, 0, 32'h0);
        fetch("addi12",  32'h04, 32'h200C0009, 0,  4, 1, 32'h9);
        fetch("add_r0",  32'h08, 32'h000C5820, 0,  4, 1, 32'h9);
        fetch("illegal", 32'h0C, 32'hFC000000, 0,  4, 0, 32'h0);
`ifdef MULTICYCLE_MIPS_TRAP_EN
        @(negedge clk);
        chk1("trap halt", halt, 1'b1);
        chk32("trap pc", IR_addr, 32'h10);
        held = 0;
        repeat (6) begin
            @(negedge clk);
            if (IR_req === 1'b0 && halt === 1'b1) held++;
        end
        chk32("trap stays", held, 6);
`else
        fetch("after_nop", 32'h10, 32'h200DFFFF, 0, 2, 1, 32'hFFFFFFFF);
        chk1("nop halt", halt, 1'b0);
        wait_req("drain");
        if (exp_q.size() > 0) chk32("drain wd", RF_writedata, exp_q.pop_front());
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_mips.md
# multicycle_mips

Multi-cycle MIPS core: the successor to the single-cycle datapath, sharing one ALU across IF/ID/EX/MEM/WB states driven by an FSM. Instruction and data memory are reached through ready-qualified handshakes, so slow SRAM or cache models can stall the core. Data-memory address width is parametrised, and `jal`/`jr`/`addi`/`ori` are supported. The block sits between the testbench instruction ROM and the data SRAM model, and exposes `RF_writedata` for checking.

## Interface
Parameters:
- `DMEM_AW`, 7: data-memory word-address width (width of `A`).
- `RESET_PC`, 32'h0: PC value after reset.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `IR_addr`  out  32  byte address of the instruction being fetched (= PC).
- `IR_req`  out  1  fetch request, high only in IF.
- `IR`  in  32  instruction word, valid when `IR_valid`.
- `IR_valid`  in  1  instruction-memory ready; sampled only in IF.
- `CEN`  out  1  data-memory chip enable, active low.
- `OEN`  out  1  output enable, active low; low for loads only.
- `WEN`  out  1  write enable, active low; low for stores only.
- `A`  out  `DMEM_AW`  data word address = ALU result bits [`DMEM_AW`+1:2].
- `WriteDataMem`  out  32  store data (rt).
- `ReadDataMem`  in  32  load data, valid when `Mem_ready`.
- `Mem_ready`  in  1  data-memory access complete; sampled only in MEM.
- `RF_writedata`  out  32  last value written to RF; held between writes.
- `halt`  out  1  core halted (see Configuration).

## Operation
- Instructions:
  - R-type: `add`, `sub`, `and`, `or`, `slt`, `jr`.
  - I-type: `addi` (sign-extended immediate), `ori` (zero-extended immediate), `lw`, `sw`, `beq`.
  - J-type: `j`, `jal`.
- Register file: 32x32. `$0` reads 0 and ignores writes.
- FSM states: IF, ID, EX, MEM, WB, HALT.
- IF:
  - `IR_req`=1, `IR_addr`=PC; stay in IF while `IR_valid`=0.
  - On `IR_valid`=1: latch IR, PC<=PC+4, go to ID.
- ID: register rs/rt into A/B, sign-extend imm, decode; go to EX.
- EX, by instruction class:
  - R-ALU/addi/ori: ALUOut <= result; go to WB.
  - lw/sw: ALUOut <= rs+sext(imm); go to MEM.
  - beq: if rs==rt, PC <= PC + (sext(imm)<<2), where PC already holds PC+4; go to IF.
  - j: PC <= {PC[31:28], IR[25:0], 2'b00}; go to IF.
  - jal: same target as j, and $31 <= old PC (the instruction's PC+4) in this cycle; go to IF.
  - jr: PC <= rs; go to IF.
- MEM:
  - `CEN`=0, `A` held stable, plus `OEN`=0 (lw) or `WEN`=0 (sw, `WriteDataMem`=rt).
  - Hold all of these until `Mem_ready`=1 is sampled.
  - Then lw latches `ReadDataMem` into MDR and goes to WB; sw goes to IF.
- WB:
  - Destination: rd for R-type, rt for I-type.
  - Data: MDR for lw, ALUOut otherwise.
  - `RF_writedata` updates in the same edge as the write; go to IF.
- Arithmetic: 32-bit wrap, no overflow trap. `slt` is signed. `A` truncates upper address bits silently.

## Timing
- Reset values: PC=`RESET_PC`, state=IF, all RF=0, `RF_writedata`=0, `halt`=0, `IR_req`=0 in the reset cycle.
  - `CEN`=`OEN`=`WEN`=1, `A`=0, `WriteDataMem`=0.
- Cycles per instruction with zero wait states:
  - beq/j/jal/jr: 3.
  - R-type/addi/ori/sw: 4.
  - lw: 5.
  - Each stall cycle (`IR_valid`=0 in IF, `Mem_ready`=0 in MEM) adds exactly 1.
- `IR_valid` may be high in the first IF cycle (zero-wait). `IR_valid` outside IF is ignored.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- Reset mid-access: on the next edge, MEM is abandoned and `CEN`/`WEN`/`OEN` return to 1. No partial RF write occurs.
- Simultaneous `rst` and `Mem_ready`/`IR_valid`: reset wins.
- `jal` while rs/rt is $31: ID values are used; the write takes effect afterwards.

## Configuration
- `MULTICYCLE_MIPS_TRAP_EN` defined:
  - An unrecognised opcode/funct in ID moves the core to HALT.
  - `halt`=1 from the next cycle; PC freezes at the faulting instruction's PC+4.
  - HALT is left only by `rst`.
- Undefined: unrecognised instructions execute as NOP (ID → IF, 2 cycles); `halt` is tied to 0.

## Test plan
- Reset: hold `rst` 2 cycles → `IR_addr`=0, `CEN`=1, `RF_writedata`=0; first `IR_req` in the cycle after `rst` falls.
- `addi $1,$0,5`; `addi $2,$0,-3`; `slt $3,$2,$1` → `RF_writedata`=5, then 32'hFFFFFFFD, then 1; 4 cycles each.
- `sw $1,8($0)` then `lw $4,8($0)` with `Mem_ready` held low 2 cycles → `A`=2, `WEN`=0 for 3 cycles, `OEN`=0 on the load; $4=5; lw takes 7 cycles.
- `beq $1,$1,-1` at PC 0x10 → next `IR_addr`=0x10. `jal 0x40` at PC 0x20 → $31=0x24, `IR_addr`=0x100. `jr $31` → `IR_addr`=0x24.
- `IR_valid` low 3 cycles in IF, then `rst` asserted mid-MEM of a lw → no RF write, PC=0, strobes=1 next cycle.
- Opcode 6'h3F: with `MULTICYCLE_MIPS_TRAP_EN`, `halt`=1 and `IR_req` stays 0; without it, PC advances by 4 after 2 cycles.
